mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_LSU_STREAK, default 4: max consecutive load/store grants while fetch waits (1..15).
REQ-002 SHALL have parameter ADDR_W, default 16: RAM address width.
REQ-003 SHALL use one clock; reset is synchronous and active-low; ports named clk and reset_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 if_req  in  1  fetch read request.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_flush  in  1  jump redirect; kills fetch traffic.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  fetch read data valid.
REQ-011 if_rdata  out  32  fetch read data.
REQ-012 ls_req  in  1  load/store request.
REQ-013 ls_we  in  1  1 = store, 0 = load.
REQ-014 ls_addr  in  ADDR_W  load/store address.
REQ-015 ls_wdata  in  32  store data.
REQ-016 ls_gnt  out  1  load/store request accepted this cycle.
REQ-017 ls_rvalid  out  1  load data valid.
REQ-018 ls_rdata  out  32  load data.
REQ-019 ram_rd_en / ram_rd_addr  out  1 / ADDR_W  RAM read command.
REQ-020 ram_rd_data  in  32  RAM read data, valid one cycle after ram_rd_en.
REQ-021 ram_wr_en / ram_wr_addr / ram_wr_data  out  1 / ADDR_W / 32  RAM write command.

Function
REQ-022 SHALL issue at most one RAM command (read or write) per cycle; ram_rd_en and ram_wr_en never both 1.
REQ-023 Grants combinational from current inputs and state; a granted request drives its RAM command in the same cycle.
REQ-024 Default priority: ls_req wins over if_req.
REQ-025 streak counter: +1 on each ls grant while if_req=1 and if_flush=0, saturating at MAX_LSU_STREAK; cleared on any if grant or any cycle with if_req=0.
REQ-026 When streak == MAX_LSU_STREAK and if_req=1 and if_flush=0, fetch SHALL win over ls_req.
REQ-027 Fetch grant: ram_rd_en=1, ram_rd_addr=if_addr. Load grant: ram_rd_en=1, ram_rd_addr=ls_addr. Store grant: ram_wr_en=1, ram_wr_addr=ls_addr, ram_wr_data=ls_wdata.
REQ-028 Store completes in its grant cycle; no ls_rvalid for stores.
REQ-029 Pending-read owner register: states NONE, FETCH, LOAD; set on the read grant edge, and next cycle it selects the rvalid target.
REQ-030 Read latency exactly 1 cycle: owner's rvalid=1 the cycle after grant; rdata = ram_rd_data that cycle; other requester's rvalid=0.
REQ-031 Back-to-back reads SHALL be pipelined: a new read may be granted in the same cycle a prior read's rvalid is asserted.
REQ-032 if_rdata/ls_rdata are don't-care when corresponding rvalid=0; bench checks only under rvalid.
REQ-033 if_flush=1: if_gnt=0 that cycle; ls may be granted.
REQ-034 if_flush=1 while owner==FETCH: if_rvalid=0 that cycle (returning fetch data discarded).
REQ-035 if_flush SHALL NOT affect a pending LOAD; ls_rvalid delivered normally.
REQ-036 Address/data inputs sampled only in grant cycle; requester holds req until gnt.

Reset
REQ-037 reset_n=0 at rising clk: owner=NONE, streak=0.
REQ-038 During reset cycle and the cycle after: if_gnt, ls_gnt, if_rvalid, ls_rvalid, ram_rd_en, ram_wr_en all 0; a read granted before reset produces no rvalid.
REQ-039 Reset mid-operation discards any in-flight read; no RAM write issued while reset_n=0.

Verification
REQ-040 Fetch only: if_req=1 if_addr=0x0010 -> if_gnt=1, ram_rd_addr=0x0010; next cycle ram_rd_data=0xDEADBEEF -> if_rvalid=1, if_rdata=0xDEADBEEF, ls_rvalid=0.
REQ-041 Contention: if_req=1, ls_req=1 ls_we=0 for 6 cycles, MAX_LSU_STREAK=4 -> grants LS,LS,LS,LS,IF,LS; streak 0 after IF grant.
REQ-042 Store vs fetch: ls_req=1 ls_we=1 ls_addr=0x0100 ls_wdata=0x12345678 with if_req=1 -> ram_wr_en=1 same cycle, if_gnt=0, ram_rd_en=0; next cycle if_gnt=1.
REQ-043 Flush: fetch granted at 0x0020, if_flush=1 next cycle -> if_rvalid=0, if_gnt=0; load granted in the flush cycle returns ls_rvalid=1 one cycle later.
REQ-044 Pipelined reads: alternating IF/LS reads 4 cycles -> rvalid alternates to correct owner each cycle with matching ram_rd_data.
REQ-045 Reset mid-read: load granted, reset_n=0 next edge -> ls_rvalid=0, all command/grant outputs 0 until reset_n=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port-per-direction RAM between an instruction fetch port and a load/store port.
// Load/store normally wins, with a streak limit so fetch is not starved.
module mem_port_arbiter #(
    parameter int MAX_LSU_STREAK = 4,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,

    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [31:0]       ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [31:0]       ram_wr_data
);

    // Pending-read owner
    // state     | meaning
    // OWN_NONE  | no read returning this cycle
    // OWN_FETCH | RAM data this cycle belongs to fetch
    // OWN_LOAD  | RAM data this cycle belongs to a load
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

    owner_t     owner_q, owner_d;
    logic [3:0] streak_q, streak_d;
    logic       ready_q;
    logic       arb_en;
    logic       if_ok;
    logic       fetch_first;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q  <= OWN_NONE;
            streak_q <= 4'd0;
            ready_q  <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            ready_q  <= 1'b1;
        end
    end

    // ready_q keeps grants off for the first cycle after reset is released.
    always_comb begin
        arb_en      = reset_n && ready_q;
        if_ok       = if_req && !if_flush;
        fetch_first = if_ok && (streak_q == STREAK_MAX);

        ls_gnt      = arb_en && ls_req && !fetch_first;
        if_gnt      = arb_en && if_ok && (fetch_first || !ls_req);

        ram_rd_en   = if_gnt || (ls_gnt && !ls_we);
        ram_rd_addr = if_gnt ? if_addr : ls_addr;
        ram_wr_en   = ls_gnt && ls_we;
        ram_wr_addr = ls_addr;
        ram_wr_data = ls_wdata;

        streak_d = streak_q;
        if (if_gnt || !if_req) begin
            streak_d = 4'd0;
        end else if (ls_gnt && if_ok && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_FETCH;
        end else if (ls_gnt && !ls_we) begin
            owner_d = OWN_LOAD;
        end
    end

    // A flush discards fetch data already in flight; loads are never affected.
    always_comb begin
        if_rvalid = reset_n && (owner_q == OWN_FETCH) && !if_flush;
        ls_rvalid = reset_n && (owner_q == OWN_LOAD);
        if_rdata  = ram_rd_data;
        ls_rdata  = ram_rd_data;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; read returns are tracked in a scoreboard queue
// filled at grant time and drained the following cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ram_rd_en;
    logic [15:0] ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        ram_wr_en;
    logic [15:0] ram_wr_addr;
    logic [31:0] ram_wr_data;

    mem_port_arbiter #(.MAX_LSU_STREAK(4), .ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  own;   // 1 = fetch, 2 = load
        logic [31:0] data;
    } rd_t;

    rd_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  n_push = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus with the expected grant pattern supplied by the caller.
    task automatic cycle(input string tag, input logic ifr, input logic [15:0] ifa,
                         input logic fl, input logic lsr, input logic we,
                         input logic [15:0] lsa, input logic [31:0] wd,
                         input logic e_if, input logic e_ls);
        rd_t  resp;
        logic has_resp;
        logic e_rd, e_wr;
        has_resp = 1'b0;
        resp.own = 2'd0;
        resp.data = 32'h0;
        if (sb.size() > 0) begin
            resp = sb.pop_front();
            has_resp = 1'b1;
        end
        reset_n     = 1'b1;
        if_req      = ifr;
        if_addr     = ifa;
        if_flush    = fl;
        ls_req      = lsr;
        ls_we       = we;
        ls_addr     = lsa;
        ls_wdata    = wd;
        ram_rd_data = has_resp ? resp.data : $urandom;
        e_rd = e_if || (e_ls && !we);
        e_wr = e_ls && we;
        @(negedge clk);
        chk({tag, ".if_gnt"},    32'(if_gnt),    32'(e_if));
        chk({tag, ".ls_gnt"},    32'(ls_gnt),    32'(e_ls));
        chk({tag, ".ram_rd_en"}, 32'(ram_rd_en), 32'(e_rd));
        chk({tag, ".ram_wr_en"}, 32'(ram_wr_en), 32'(e_wr));
        if (e_rd) chk({tag, ".ram_rd_addr"}, 32'(ram_rd_addr), 32'(e_if ? ifa : lsa));
        if (e_wr) begin
            chk({tag, ".ram_wr_addr"}, 32'(ram_wr_addr), 32'(lsa));
            chk({tag, ".ram_wr_data"}, ram_wr_data, wd);
        end
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(has_resp && resp.own == 2'd1 && !fl));
        chk({tag, ".ls_rvalid"}, 32'(ls_rvalid), 32'(has_resp && resp.own == 2'd2));
        if (has_resp && resp.own == 2'd1 && !fl) chk({tag, ".if_rdata"}, if_rdata, resp.data);
        if (has_resp && resp.own == 2'd2)        chk({tag, ".ls_rdata"}, ls_rdata, resp.data);
        if (e_rd) begin
            rd_t nr;
            nr.own  = e_if ? 2'd1 : 2'd2;
            nr.data = 32'hDEADBEEF ^ (32'(n_push) * 32'h01010101);
            n_push++;
            sb.push_back(nr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string tag);
        reset_n     = 1'b0;
        if_req      = 1'b1;
        if_addr     = 16'h0040;
        if_flush    = 1'b0;
        ls_req      = 1'b1;
        ls_we       = 1'b1;
        ls_addr     = 16'h0044;
        ls_wdata    = 32'hA5A5A5A5;
        ram_rd_data = $urandom;
        @(negedge clk);
        chk({tag, ".if_gnt"},    32'(if_gnt),    32'h0);
        chk({tag, ".ls_gnt"},    32'(ls_gnt),    32'h0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'h0);
        chk({tag, ".ls_rvalid"}, 32'(ls_rvalid), 32'h0);
        chk({tag, ".ram_rd_en"}, 32'(ram_rd_en), 32'h0);
        chk({tag, ".ram_wr_en"}, 32'(ram_wr_en), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 16'h0, 0, 0, 0, 16'h0, 32'h0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ram_rd_data = '0;

        reset_cycle("rst0");
        reset_cycle("rst1");
        cycle("post_rst", 1, 16'h0008, 0, 1, 0, 16'h0200, 32'h0, 0, 0);

        // Single fetch, data returned one cycle later.
        cycle("fetch", 1, 16'h0010, 0, 0, 0, 16'h0, 32'h0, 1, 0);
        idle("fetch_ret");

        // Contention: ls wins four times, then fetch; streak restarts after the fetch grant.
        for (int i = 0; i < 10; i++) begin
            logic e_if;
            e_if = (i == 4) || (i == 9);
            cycle($sformatf("cont%0d", i), 1, 16'h0100 + 16'(i), 0, 1, 0,
                  16'h0300 + 16'(i), 32'h0, e_if, !e_if);
        end
        idle("cont_drain");

        // A cycle without if_req clears the streak.
        for (int i = 0; i < 3; i++)
            cycle($sformatf("clr_a%0d", i), 1, 16'h0400, 0, 1, 0, 16'h0500 + 16'(i), 32'h0, 0, 1);
        cycle("clr_gap", 0, 16'h0, 0, 1, 0, 16'h0510, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("clr_b%0d", i), 1, 16'h0400, 0, 1, 0, 16'h0520 + 16'(i),
                  32'h0, i == 4, i != 4);
        idle("clr_drain");

        // Store beats fetch, fetch goes next.
        cycle("store", 1, 16'h0030, 0, 1, 1, 16'h0100, 32'h12345678, 0, 1);
        cycle("store_if", 1, 16'h0030, 0, 0, 0, 16'h0, 32'h0, 1, 0);
        idle("store_drain");

        // Flush discards returning fetch data; a load granted in the flush cycle returns normally.
        cycle("flush_if", 1, 16'h0020, 0, 0, 0, 16'h0, 32'h0, 1, 0);
        cycle("flush", 1, 16'h0024, 1, 1, 0, 16'h0600, 32'h0, 0, 1);
        idle("flush_ld_ret");

        // Pipelined alternating reads.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                cycle($sformatf("pipe%0d", i), 1, 16'h0700 + 16'(i), 0, 0, 0, 16'h0, 32'h0, 1, 0);
            else
                cycle($sformatf("pipe%0d", i), 0, 16'h0, 0, 1, 0, 16'h0800 + 16'(i), 32'h0, 0, 1);
        end
        idle("pipe_drain");

        // Reset with a load in flight.
        cycle("rst_ld", 0, 16'h0, 0, 1, 0, 16'h0900, 32'h0, 0, 1);
        reset_cycle("rst_mid");
        cycle("rst_mid_post", 1, 16'h0A00, 0, 1, 0, 16'h0A04, 32'h0, 0, 0);
        cycle("rst_mid_if", 1, 16'h0A00, 0, 0, 0, 16'h0, 32'h0, 1, 0);
        idle("rst_mid_ret");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
